// File: rtl/sa_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sa_ctrl_pkg
//   Shared definitions for the 3x3 systolic-array control slice: sequencer
//   state encoding, SRAM layout constants, mode encodings, bus widths and a
//   small wrapping address-add helper.
// ----------------------------------------------------------------------------
package sa_ctrl_pkg;

    // Bus widths of the sequencer interface
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned TILE_W = 2;

    // Shared SRAM layout: the 9 weights sit at the bottom of the address space
    localparam int unsigned SRAM_W_BASE = 0;
    localparam int unsigned N_WEIGHTS   = 9;

    // SRAM read-path select
    localparam logic MODE_WEIGHT  = 1'b0;
    localparam logic MODE_FEATURE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_SWITCH = 3'd2,
        ST_LOAD_F = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_FIN    = 3'd6
    } seq_state_e;

    // Address add that wraps modulo 2**ADDR_W; no carry out by design
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// ----------------------------------------------------------------------------
// systolic_tile_sequencer_if
//   Groups the host handshake and datapath control signals of the tile
//   sequencer.
//   master : the sequencer itself (consumes start/reuse_w/loader dones,
//            drives enables, addressing, mode and status)
//   slave  : the host controller plus datapath loaders on the other side
//   Signals:
//     start, reuse_w               host job request / weight-reuse hint
//     is_WL_done_i, is_FL_done_i   loader completion indications
//     Weight_Preloader_en          weight preloader enable
//     Feature_Loader_en            feature loader enable
//     feature_baseaddr [5:0]       feature base address of current pass
//     mode                         0 = weight path, 1 = feature path
//     c_sel [1:0], tile_idx [1:0]  output tile select / pass number
//     busy, done, error            job status
//     weights_valid                SA holds a valid weight set
// ----------------------------------------------------------------------------
interface systolic_tile_sequencer_if;
    import sa_ctrl_pkg::*;

    logic              start;
    logic              reuse_w;
    logic              is_WL_done_i;
    logic              is_FL_done_i;
    logic              Weight_Preloader_en;
    logic              Feature_Loader_en;
    logic [ADDR_W-1:0] feature_baseaddr;
    logic              mode;
    logic [TILE_W-1:0] c_sel;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
    logic              error;
    logic              weights_valid;

    modport master (
        input  start, reuse_w, is_WL_done_i, is_FL_done_i,
        output Weight_Preloader_en, Feature_Loader_en, feature_baseaddr, mode,
               c_sel, tile_idx, busy, done, error, weights_valid
    );

    modport slave (
        output start, reuse_w, is_WL_done_i, is_FL_done_i,
        input  Weight_Preloader_en, Feature_Loader_en, feature_baseaddr, mode,
               c_sel, tile_idx, busy, done, error, weights_valid
    );

endinterface

// File: rtl/sa_cycle_counter.sv
// ----------------------------------------------------------------------------
// sa_cycle_counter
//   Up-counter with synchronous clear-load, count enable and a fixed
//   terminal-count compare. Used by the sequencer as both its load-state
//   watchdog and its drain timer.
//   Ports:
//     clk     in  clock, rising edge
//     rst     in  synchronous active-high reset
//     i_load  in  clear count to zero (priority over i_en)
//     i_en    in  increment count
//     o_tc    out count equals TERMINAL
// ----------------------------------------------------------------------------
module sa_cycle_counter #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_tc = (r_cnt == WIDTH'(TERMINAL));

endmodule

// File: rtl/systolic_tile_sequencer.sv
// ----------------------------------------------------------------------------
// systolic_tile_sequencer
//   Top-level control FSM for the 3x3 systolic datapath. A job preloads the
//   9 weights (unless reusable weights are already held), then runs
//   NUM_TILES feature passes. Each pass selects the feature base address and
//   output tile c_sel, and is followed by a drain period covering the
//   datapath's c_sel pipeline. A watchdog aborts a stalled load state.
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  synchronous active-high reset
//     bus   master modport of systolic_tile_sequencer_if (host handshake,
//           loader enables/dones, addressing, mode, status)
// ----------------------------------------------------------------------------
module systolic_tile_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TILES    = 4,
    parameter int unsigned FEAT_BASE0   = 9,
    parameter int unsigned FEAT_STRIDE  = 3,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 63
) (
    input  logic                        clk,
    input  logic                        rst,
    systolic_tile_sequencer_if.master   bus
);

    localparam int unsigned CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    generate
        if (NUM_TILES < 1 || NUM_TILES > (1 << TILE_W)) begin : g_bad_tiles
            $error("NUM_TILES must be in 1..4");
        end
        if (FEAT_BASE0 >= (1 << ADDR_W)) begin : g_bad_base
            $error("FEAT_BASE0 does not fit the feature address bus");
        end
        if (FEAT_BASE0 < SRAM_W_BASE + N_WEIGHTS) begin : g_overlap
            $error("FEAT_BASE0 overlaps the weight region");
        end
        if (TIMEOUT < 1 || DRAIN_CYCLES < 1) begin : g_bad_cnt
            $error("TIMEOUT and DRAIN_CYCLES must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    seq_state_e        r_state;
    logic [TILE_W-1:0] r_tile;
    logic [TILE_W-1:0] r_csel;
    logic [ADDR_W-1:0] r_base;
    logic              r_mode;
    logic              r_wl_en;
    logic              r_fl_en;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_wvalid;

    seq_state_e        w_nxt_state;
    logic [TILE_W-1:0] w_nxt_tile;
    logic [TILE_W-1:0] w_nxt_csel;
    logic [ADDR_W-1:0] w_nxt_base;
    logic              w_nxt_mode;
    logic              w_nxt_done;
    logic              w_nxt_error;
    logic              w_nxt_wvalid;

    logic              w_wd_load;
    logic              w_wd_en;
    logic              w_wd_tc;
    logic              w_dr_load;
    logic              w_dr_en;
    logic              w_dr_tc;
    logic              w_last_tile;

    assign w_last_tile = (r_tile == TILE_W'(NUM_TILES - 1));

    // ------------------------------------------------------------------
    // Watchdog: cleared on entry to a load state, counts while in it.
    // Terminal count TIMEOUT-1 gives exactly TIMEOUT cycles in the state.
    // ------------------------------------------------------------------
    assign w_wd_en   = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_F);
    assign w_wd_load = ((w_nxt_state == ST_LOAD_W) || (w_nxt_state == ST_LOAD_F))
                       && (w_nxt_state != r_state);

    sa_cycle_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_wd_load),
        .i_en   (w_wd_en),
        .o_tc   (w_wd_tc)
    );

    // Drain timer: DRAIN_CYCLES cycles spent in DRAIN
    assign w_dr_en   = (r_state == ST_DRAIN);
    assign w_dr_load = (w_nxt_state == ST_DRAIN) && (r_state != ST_DRAIN);

    sa_cycle_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (DRAIN_CYCLES - 1)
    ) u_drain_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_dr_load),
        .i_en   (w_dr_en),
        .o_tc   (w_dr_tc)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_tile   = r_tile;
        w_nxt_csel   = r_csel;
        w_nxt_base   = r_base;
        w_nxt_mode   = r_mode;
        w_nxt_done   = 1'b0;
        w_nxt_error  = r_error;
        w_nxt_wvalid = r_wvalid;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_nxt_error = 1'b0;
                    w_nxt_tile  = '0;
                    w_nxt_base  = ADDR_W'(FEAT_BASE0);
                    if (bus.reuse_w && r_wvalid) begin
                        w_nxt_state = ST_LOAD_F;
                        w_nxt_mode  = MODE_FEATURE;
                        w_nxt_csel  = '0;
                    end else begin
                        w_nxt_state  = ST_LOAD_W;
                        w_nxt_mode   = MODE_WEIGHT;
                        w_nxt_wvalid = 1'b0;
                    end
                end
            end

            ST_LOAD_W: begin
                // Loader completion takes priority over a same-cycle timeout
                if (bus.is_WL_done_i) begin
                    w_nxt_state  = ST_SWITCH;
                    w_nxt_mode   = MODE_FEATURE;
                    w_nxt_wvalid = 1'b1;
                end else if (w_wd_tc) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_error  = 1'b1;
                    w_nxt_wvalid = 1'b0;
                end
            end

            // One idle cycle lets the datapath's registered mode settle
            ST_SWITCH: begin
                w_nxt_state = ST_LOAD_F;
                w_nxt_csel  = r_tile;
            end

            ST_LOAD_F: begin
                if (bus.is_FL_done_i) begin
                    w_nxt_state = ST_DRAIN;
                end else if (w_wd_tc) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_error  = 1'b1;
                    w_nxt_wvalid = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (w_dr_tc) begin
                    w_nxt_state = w_last_tile ? ST_FIN : ST_NEXT;
                end
            end

            ST_NEXT: begin
                w_nxt_state = ST_LOAD_F;
                w_nxt_tile  = r_tile + TILE_W'(1);
                w_nxt_csel  = r_tile + TILE_W'(1);
                w_nxt_base  = wrap_add(r_base, ADDR_W'(FEAT_STRIDE));
            end

            ST_FIN: begin
                w_nxt_state = ST_IDLE;
                w_nxt_done  = 1'b1;
            end

            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Enables and busy are decoded from the next state so they
    // line up with the state they describe; done is registered from FIN, so
    // it appears in the first IDLE cycle, coinciding with busy falling.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tile   <= '0;
            r_csel   <= '0;
            r_base   <= '0;
            r_mode   <= 1'b0;
            r_wl_en  <= 1'b0;
            r_fl_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_wvalid <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_tile   <= w_nxt_tile;
            r_csel   <= w_nxt_csel;
            r_base   <= w_nxt_base;
            r_mode   <= w_nxt_mode;
            r_wl_en  <= (w_nxt_state == ST_LOAD_W);
            r_fl_en  <= (w_nxt_state == ST_LOAD_F);
            r_busy   <= (w_nxt_state != ST_IDLE);
            r_done   <= w_nxt_done;
            r_error  <= w_nxt_error;
            r_wvalid <= w_nxt_wvalid;
        end
    end

    assign bus.Weight_Preloader_en = r_wl_en;
    assign bus.Feature_Loader_en   = r_fl_en;
    assign bus.feature_baseaddr    = r_base;
    assign bus.mode                = r_mode;
    assign bus.c_sel               = r_csel;
    assign bus.tile_idx            = r_tile;
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.error               = r_error;
    assign bus.weights_valid       = r_wvalid;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_systolic_tile_sequencer
//   Directed bench for systolic_tile_sequencer. Two instances run in
//   lockstep on identical inputs: one with default parameters and one with
//   FEAT_BASE0=60 to exercise 6-bit base address wrap.
// ----------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

    localparam int unsigned NUM_TILES = 4;
    localparam int unsigned DRAIN_GAP = 5;   // 4 DRAIN cycles + 1 NEXT/FIN cycle
    localparam int unsigned NO_ABORT  = 99;

    logic clk;
    logic rst;

    systolic_tile_sequencer_if u_if ();
    systolic_tile_sequencer_if u_if2 ();

    systolic_tile_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    systolic_tile_sequencer #(
        .FEAT_BASE0  (60),
        .FEAT_STRIDE (3)
    ) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (u_if2)
    );

    assign u_if2.start        = u_if.start;
    assign u_if2.reuse_w      = u_if.reuse_w;
    assign u_if2.is_WL_done_i = u_if.is_WL_done_i;
    assign u_if2.is_FL_done_i = u_if.is_FL_done_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned done_seen = 0;
    logic        prev_busy = 1'b0;
    logic        busy_before_done = 1'b0;
    bit          model_wvalid = 1'b0;

    int unsigned exp_base  [NUM_TILES] = '{9, 12, 15, 18};
    int unsigned exp_base2 [NUM_TILES] = '{60, 63, 2, 5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (u_if.done === 1'b1) begin
            done_seen++;
            busy_before_done = prev_busy;
        end
        prev_busy = u_if.busy;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  u_if.busy, 0);
        check({tag, "_done"},  u_if.done, 0);
        check({tag, "_err"},   u_if.error, 0);
        check({tag, "_wv"},    u_if.weights_valid, 0);
        check({tag, "_wl_en"}, u_if.Weight_Preloader_en, 0);
        check({tag, "_fl_en"}, u_if.Feature_Loader_en, 0);
        check({tag, "_base"},  u_if.feature_baseaddr, 0);
        check({tag, "_csel"},  u_if.c_sel, 0);
        check({tag, "_tile"},  u_if.tile_idx, 0);
        check({tag, "_mode"},  u_if.mode, 0);
        check({tag, "_base2"}, u_if2.feature_baseaddr, 0);
    endtask

    // Plays host + loaders: WL_done 10 cycles into LOAD_W, FL_done 12 cycles
    // after each LOAD_F entry. Optional disturbance in pass 1, optional
    // reset during DRAIN of pass abort_pass.
    task automatic run_job(input string name, input bit reuse, input bit disturb,
                           input int unsigned abort_pass);
        bit          skip;
        int unsigned n;
        skip = reuse && model_wvalid;
        done_seen = 0;

        u_if.start = 1'b1;
        u_if.reuse_w = reuse;
        tick();
        u_if.start = 1'b0;
        u_if.reuse_w = 1'b0;
        check({name, "_busy"}, u_if.busy, 1);
        check({name, "_err_clr"}, u_if.error, 0);

        if (!skip) begin
            check({name, "_wl_en"}, u_if.Weight_Preloader_en, 1);
            check({name, "_wl_fl_en"}, u_if.Feature_Loader_en, 0);
            check({name, "_wl_mode"}, u_if.mode, 0);
            check({name, "_wl_wv"}, u_if.weights_valid, 0);
            repeat (9) tick();
            check({name, "_wl_hold"}, u_if.Weight_Preloader_en, 1);
            u_if.is_WL_done_i = 1'b1;
            tick();
            u_if.is_WL_done_i = 1'b0;
            check({name, "_sw_wl_en"}, u_if.Weight_Preloader_en, 0);
            check({name, "_sw_fl_en"}, u_if.Feature_Loader_en, 0);
            check({name, "_sw_mode"}, u_if.mode, 1);
            check({name, "_sw_wv"}, u_if.weights_valid, 1);
            tick();
        end else begin
            check({name, "_skip_wl_en"}, u_if.Weight_Preloader_en, 0);
            check({name, "_skip_wv"}, u_if.weights_valid, 1);
        end

        for (int p = 0; p < NUM_TILES; p++) begin
            check({name, "_p_fl_en"}, u_if.Feature_Loader_en, 1);
            check({name, "_p_wl_en"}, u_if.Weight_Preloader_en, 0);
            check({name, "_p_mode"}, u_if.mode, 1);
            check({name, "_p_tile"}, u_if.tile_idx, p);
            check({name, "_p_csel"}, u_if.c_sel, p);
            check({name, "_p_base"}, u_if.feature_baseaddr, exp_base[p]);
            check({name, "_p_base2"}, u_if2.feature_baseaddr, exp_base2[p]);
            for (int k = 1; k <= 11; k++) begin
                if (disturb && p == 1 && k == 3) u_if.start = 1'b1;
                if (disturb && p == 1 && k == 5) u_if.is_WL_done_i = 1'b1;
                tick();
                u_if.start = 1'b0;
                u_if.is_WL_done_i = 1'b0;
            end
            check({name, "_fl_hold"}, u_if.Feature_Loader_en, 1);
            check({name, "_fl_hold_tile"}, u_if.tile_idx, p);
            u_if.is_FL_done_i = 1'b1;
            tick();
            u_if.is_FL_done_i = 1'b0;
            check({name, "_dr_fl_en"}, u_if.Feature_Loader_en, 0);
            check({name, "_dr_csel"}, u_if.c_sel, p);
            check({name, "_dr_base"}, u_if.feature_baseaddr, exp_base[p]);

            if (p == abort_pass) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_all_zero({name, "_rst"});
                model_wvalid = 1'b0;
                return;
            end

            n = 0;
            while (u_if.busy && !u_if.Feature_Loader_en && n < 20) begin
                n++;
                tick();
            end
            check({name, "_gap"}, n, DRAIN_GAP);
        end

        check({name, "_done"}, u_if.done, 1);
        check({name, "_busy_at_done"}, u_if.busy, 0);
        check({name, "_busy_before_done"}, busy_before_done, 1);
        check({name, "_end_wv"}, u_if.weights_valid, 1);
        tick();
        tick();
        check({name, "_done_cnt"}, done_seen, 1);
        check({name, "_done_low"}, u_if.done, 0);
        check({name, "_idle_after"}, u_if.busy, 0);
        model_wvalid = 1'b1;
    endtask

    task automatic run_timeout();
        int unsigned n;
        done_seen = 0;
        u_if.start = 1'b1;
        u_if.reuse_w = 1'b0;
        tick();
        u_if.start = 1'b0;
        n = 0;
        while (u_if.Weight_Preloader_en && n < 100) begin
            n++;
            tick();
        end
        check("to_wl_cycles", n, 63);
        check("to_wl_en", u_if.Weight_Preloader_en, 0);
        check("to_error", u_if.error, 1);
        check("to_wv", u_if.weights_valid, 0);
        check("to_busy", u_if.busy, 0);
        check("to_done", u_if.done, 0);
        repeat (3) tick();
        check("to_no_done", done_seen, 0);
        check("to_err_sticky", u_if.error, 1);
        model_wvalid = 1'b0;
    endtask

    initial begin
        u_if.start = 1'b0;
        u_if.reuse_w = 1'b0;
        u_if.is_WL_done_i = 1'b0;
        u_if.is_FL_done_i = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        run_job("t1_full", 1'b0, 1'b0, NO_ABORT);
        run_job("t2_reuse", 1'b1, 1'b0, NO_ABORT);
        run_timeout();
        run_job("t3_recover", 1'b0, 1'b0, NO_ABORT);
        run_job("t4_disturb", 1'b1, 1'b1, NO_ABORT);
        run_job("t5_abort", 1'b0, 1'b0, 2);
        run_job("t5_restart", 1'b1, 1'b0, NO_ABORT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed simulation still running, expected completion");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
